// File: rtl/dac_spi_config.sv
// DAC bring-up sequencer: pulses the DAC hardware reset, then writes four table
// entries over 3-wire SPI. Define DAC_SPI_READBACK_EN to add per-entry readback checking.
module dac_spi_config #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned RST_CYCLES = 64,
  parameter logic [15:0] REG0       = 16'h0000,
  parameter logic [15:0] REG1       = 16'h0000,
  parameter logic [15:0] REG2       = 16'h0000,
  parameter logic [15:0] REG3       = 16'h0000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  output logic rst_out,
  output logic csb,
  output logic sclk,
  output logic sdio,
  input  logic sdo
);

  typedef enum logic [2:0] {
    IDLE, RST_ASSERT, RST_WAIT, LOAD, SHIFT, GAP, CHECK, FIN
  } state_t;

  localparam int unsigned RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);

  state_t        state;
  logic [RW-1:0] rcnt;
  logic [7:0]    div;
  logic [5:0]    hp;     // half-period index within a frame (0 = lead-in, 32 = tail)
  logic [1:0]    idx;
  logic [15:0]   shreg;
  logic [12:0]   cur;
  logic [15:0]   frame;
  logic          rd_bit;

  function automatic logic [12:0] entry(input logic [1:0] i);
    case (i)
      2'd0:    entry = REG0[12:0];
      2'd1:    entry = REG1[12:0];
      2'd2:    entry = REG2[12:0];
      default: entry = REG3[12:0];
    endcase
  endfunction

`ifdef DAC_SPI_READBACK_EN
  logic       rd;
  logic [7:0] rx;
  logic       err_q;
  assign rd_bit = rd;
  assign err    = err_q;
`else
  logic sdo_unused;
  assign sdo_unused = sdo;
  assign rd_bit     = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    cur   = entry(idx);
    frame = {rd_bit, 2'b00, cur[12:8], rd_bit ? 8'h00 : cur[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rst_out <= 1'b0;
      csb     <= 1'b1;
      sclk    <= 1'b0;
      sdio    <= 1'b0;
      rcnt    <= '0;
      div     <= '0;
      hp      <= '0;
      idx     <= '0;
      shreg   <= '0;
`ifdef DAC_SPI_READBACK_EN
      rd      <= 1'b0;
      rx      <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, FIN: if (start) begin
          state   <= RST_ASSERT;
          busy    <= 1'b1;
          done    <= 1'b0;
          rst_out <= 1'b1;
          rcnt    <= '0;
`ifdef DAC_SPI_READBACK_EN
          err_q   <= 1'b0;
`endif
        end
        RST_ASSERT: if (rcnt == RST_LAST) begin
          rcnt    <= '0;
          rst_out <= 1'b0;
          state   <= RST_WAIT;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
        RST_WAIT: if (rcnt == RST_LAST) begin
          rcnt  <= '0;
          idx   <= '0;
          state <= LOAD;
`ifdef DAC_SPI_READBACK_EN
          rd    <= 1'b0;
`endif
        end else begin
          rcnt <= rcnt + 1'b1;
        end
        LOAD: begin
          shreg <= frame;
          sdio  <= frame[15];
          csb   <= 1'b0;
          div   <= '0;
          hp    <= '0;
          state <= SHIFT;
        end
        // Even half-periods are sclk-low, odd are sclk-high; data moves on each fall.
        SHIFT: if (div == DIV_LAST) begin
          div <= '0;
          if (hp == 6'd32) begin
            csb   <= 1'b1;
            sdio  <= 1'b0;
            hp    <= '0;
            state <= GAP;
          end else begin
            hp <= hp + 1'b1;
            if (!hp[0]) begin
              sclk <= 1'b1;
`ifdef DAC_SPI_READBACK_EN
              if (rd && hp >= 6'd16) rx <= {rx[6:0], sdo};
`endif
            end else begin
              sclk  <= 1'b0;
              shreg <= {shreg[14:0], 1'b0};
              sdio  <= shreg[14];
            end
          end
        end else begin
          div <= div + 1'b1;
        end
        GAP: if (div == DIV_LAST) begin
          div <= '0;
          if (hp == 6'd0) begin
            hp <= 6'd1;
          end else begin
            hp <= '0;
`ifdef DAC_SPI_READBACK_EN
            if (!rd) begin
              rd    <= 1'b1;
              state <= LOAD;
            end else begin
              state <= CHECK;
            end
`else
            if (idx == 2'd3) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FIN;
            end else begin
              idx   <= idx + 1'b1;
              state <= LOAD;
            end
`endif
          end
        end else begin
          div <= div + 1'b1;
        end
`ifdef DAC_SPI_READBACK_EN
        CHECK: begin
          rd <= 1'b0;
          if (rx != cur[7:0] || idx == 2'd3) begin
            err_q <= (rx != cur[7:0]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx   <= idx + 1'b1;
            state <= LOAD;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
